// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Round-robin arbiter sharing one async_fifo write port between NUM_REQ
// requesters. A grant is held from the first beat of a packet until its last
// beat, so packets are never interleaved in the FIFO. Runs entirely in the
// FIFO write clock domain.
//
// Optional feature macro: ARB_MAX_BURST_EN
//   When defined, a grant is also released after MAX_BURST beats even without
//   last (streaming mode, packet atomicity is lost). When undefined, the beat
//   counter is not built and release happens only on last.
//
// Ports:
//   clk           in   write-domain clock (FIFO wclk)
//   rst_n         in   asynchronous active-low reset
//   req_valid_i   in   [NUM_REQ]           per-requester beat valid
//   req_data_i    in   [NUM_REQ*DATA_LEN]  requester k at [k*DATA_LEN +: DATA_LEN]
//   req_last_i    in   [NUM_REQ]           final beat of packet (qualified by valid)
//   req_ready_o   out  [NUM_REQ]           beat accepted when valid && ready
//   fifo_full_i   in                       FIFO full
//   fifo_wen_o    out                      FIFO write_en
//   fifo_wdata_o  out  [DATA_LEN]          FIFO data_in
//   grant_o       out  [NUM_REQ]           one-hot current owner, 0 when idle
//   grant_id_o    out  [IDW]               index of current owner, 0 when idle
//   busy_o        out                      a grant is held
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_LEN  = 32,
    parameter int MAX_BURST = 16,
    localparam int IDW      = $clog2(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid_i,
    input  logic [NUM_REQ*DATA_LEN-1:0]  req_data_i,
    input  logic [NUM_REQ-1:0]           req_last_i,
    output logic [NUM_REQ-1:0]           req_ready_o,
    input  logic                         fifo_full_i,
    output logic                         fifo_wen_o,
    output logic [DATA_LEN-1:0]          fifo_wdata_o,
    output logic [NUM_REQ-1:0]           grant_o,
    output logic [IDW-1:0]               grant_id_o,
    output logic                         busy_o
);

    // Elaboration-time range checks on the configuration.
    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("fifo_wr_arbiter: NUM_REQ must be 2..8");
    end
    if (MAX_BURST < 1 || MAX_BURST > 256) begin : g_bad_max_burst
        $error("fifo_wr_arbiter: MAX_BURST must be 1..256");
    end

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t               state_q,    state_d;
    logic [IDW-1:0]       grant_id_q, grant_id_d;
    logic [IDW-1:0]       last_id_q,  last_id_d;
    logic [NUM_REQ-1:0]   grant_q,    grant_d;

    logic                 xfer;
    logic                 release_now;
    logic                 burst_done;
    logic                 pick_vld;
    logic [IDW-1:0]       pick_id;
    logic [IDW-1:0]       cand;

`ifdef ARB_MAX_BURST_EN
    logic [7:0]           cnt_q, cnt_d;

    assign burst_done = (cnt_q == 8'(MAX_BURST - 1));
`else
    assign burst_done = 1'b0;
`endif

    // A beat moves only in LOCK, from the granted requester, while not full.
    assign xfer        = (state_q == LOCK) && req_valid_i[grant_id_q] && !fifo_full_i;
    assign release_now = xfer && (req_last_i[grant_id_q] || burst_done);

    // Round-robin search: first valid requester after last_id, wrapping.
    // i runs 1..NUM_REQ so last_id itself is considered last.
    always_comb begin
        pick_vld = 1'b0;
        pick_id  = '0;
        cand     = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = IDW'((32'(last_id_q) + i) % 32'(NUM_REQ));
            if (!pick_vld && req_valid_i[cand]) begin
                pick_vld = 1'b1;
                pick_id  = cand;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        last_id_d  = last_id_q;
        grant_d    = grant_q;
`ifdef ARB_MAX_BURST_EN
        cnt_d      = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d    = LOCK;
                    grant_id_d = pick_id;
                    grant_d    = NUM_REQ'(1) << pick_id;
`ifdef ARB_MAX_BURST_EN
                    cnt_d      = '0;
`endif
                end
            end
            LOCK: begin
`ifdef ARB_MAX_BURST_EN
                if (xfer) begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
                // grant_id is cleared on release so grant_id_o reads 0 when
                // idle; the owner is remembered in last_id for the next search.
                if (release_now) begin
                    state_d    = IDLE;
                    last_id_d  = grant_id_q;
                    grant_id_d = '0;
                    grant_d    = '0;
                end
            end
            default: begin
                state_d    = IDLE;
                grant_id_d = '0;
                grant_d    = '0;
            end
        endcase
    end

    // All FSM state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            grant_id_q <= '0;
            last_id_q  <= IDW'(NUM_REQ - 1);
            grant_q    <= '0;
`ifdef ARB_MAX_BURST_EN
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            last_id_q  <= last_id_d;
            grant_q    <= grant_d;
`ifdef ARB_MAX_BURST_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    // Ready depends only on registered grant and full, never on valid.
    always_comb begin
        req_ready_o = '0;
        if (state_q == LOCK) begin
            req_ready_o[grant_id_q] = !fifo_full_i;
        end
    end

    assign fifo_wen_o   = xfer;
    assign fifo_wdata_o = req_data_i[int'(grant_id_q) * DATA_LEN +: DATA_LEN];
    assign grant_o      = grant_q;
    assign grant_id_o   = grant_id_q;
    assign busy_o       = (state_q == LOCK);

endmodule
